// File: rtl/dmem_arb_pkg.sv
// Shared types and widths for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic {
    ARB_IDLE      = 1'b0,
    ARB_READ_WAIT = 1'b1
  } arb_state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_e;

  localparam int unsigned STARVE_CNT_W = 8;
  // Wide enough for READ_LAT-1 with READ_LAT up to 3.
  localparam int unsigned LAT_CNT_W    = 2;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle around the arbiter: CPU memory-stage port, DMA/loader port and data-memory port.
// The slave modport is the arbiter; the master modport is everything around it.
interface dmem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_stall;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_gnt;
  logic              dma_rvalid;
  logic [DATA_W-1:0] dma_rdata;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_stall, cpu_rvalid, cpu_rdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_gnt, dma_rvalid, dma_rdata,
    output mem_we, mem_addr, mem_din,
    input  mem_dout
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_stall, cpu_rvalid, cpu_rdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  mem_we, mem_addr, mem_din,
    output mem_dout
  );

endinterface

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: CPU has fixed priority, a starvation counter forces DMA grants.
// Define DMEM_ARB_PERF_EN to add the stall-cycle and forced-grant performance counters.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned READ_LAT   = 1,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic          clk,
  input  logic          rst,
  dmem_arbiter_if.slave bus
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]   perf_cpu_stall_cycles,
  output logic [31:0]   perf_dma_forced
`endif
);

  arb_state_e              state_q, state_d;
  owner_e                  owner_q, owner_d;
  logic [LAT_CNT_W-1:0]    lat_cnt_q, lat_cnt_d;
  logic [STARVE_CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic                    cpu_rvalid_q, cpu_rvalid_d;
  logic                    dma_rvalid_q, dma_rvalid_d;
  logic [DATA_W-1:0]       cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]       dma_rdata_q, dma_rdata_d;

  logic                    starved;
  logic                    mem_free;
  logic                    dma_win;
  logic                    cpu_win;
  logic                    issue;
  logic                    issue_we;
  logic [ADDR_W-1:0]       issue_addr;
  logic [DATA_W-1:0]       issue_wdata;

  // Arbitration is only live in IDLE and never while reset is asserted.
  always_comb begin
    starved     = (starve_cnt_q == STARVE_CNT_W'(STARVE_MAX));
    mem_free    = !rst && (state_q == ARB_IDLE);
    dma_win     = mem_free && bus.dma_req && (!bus.cpu_req || starved);
    cpu_win     = mem_free && bus.cpu_req && !dma_win;
    issue       = dma_win || cpu_win;
    issue_we    = dma_win ? bus.dma_we    : bus.cpu_we;
    issue_addr  = dma_win ? bus.dma_addr  : bus.cpu_addr;
    issue_wdata = dma_win ? bus.dma_wdata : bus.cpu_wdata;
  end

  assign bus.mem_we   = issue && issue_we;
  assign bus.mem_addr = issue_addr;
  assign bus.mem_din  = issue_wdata;
  assign bus.dma_gnt  = dma_win;

  // A store that issues this cycle and the load-return cycle both let the pipeline advance.
  assign bus.cpu_stall = !rst && bus.cpu_req && !(cpu_win && bus.cpu_we) && !cpu_rvalid_q;

  assign bus.cpu_rvalid = cpu_rvalid_q;
  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.dma_rvalid = dma_rvalid_q;
  assign bus.dma_rdata  = dma_rdata_q;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    lat_cnt_d    = lat_cnt_q;
    cpu_rvalid_d = 1'b0;
    dma_rvalid_d = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    dma_rdata_d  = dma_rdata_q;

    case (state_q)
      ARB_IDLE: begin
        if (issue && !issue_we) begin
          state_d   = ARB_READ_WAIT;
          owner_d   = dma_win ? OWN_DMA : OWN_CPU;
          lat_cnt_d = LAT_CNT_W'(READ_LAT - 1);
        end
      end
      ARB_READ_WAIT: begin
        if (lat_cnt_q == '0) begin
          state_d = ARB_IDLE;
          if (owner_q == OWN_DMA) begin
            dma_rdata_d  = bus.mem_dout;
            dma_rvalid_d = 1'b1;
          end else begin
            cpu_rdata_d  = bus.mem_dout;
            cpu_rvalid_d = 1'b1;
          end
        end else begin
          lat_cnt_d = lat_cnt_q - LAT_CNT_W'(1);
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    if (!bus.dma_req || dma_win) begin
      starve_cnt_d = '0;
    end else if (!starved) begin
      starve_cnt_d = starve_cnt_q + STARVE_CNT_W'(1);
    end else begin
      starve_cnt_d = starve_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      owner_q      <= OWN_CPU;
      lat_cnt_q    <= '0;
      starve_cnt_q <= '0;
      cpu_rvalid_q <= 1'b0;
      dma_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      dma_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      lat_cnt_q    <= lat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      dma_rvalid_q <= dma_rvalid_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dma_rdata_q  <= dma_rdata_d;
    end
  end

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perf_stall_q;
  logic [31:0] perf_forced_q;

  // A forced grant is one the CPU would otherwise have taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q  <= '0;
      perf_forced_q <= '0;
    end else begin
      if (bus.cpu_stall && (perf_stall_q != '1)) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
      if (dma_win && bus.cpu_req && (perf_forced_q != '1)) begin
        perf_forced_q <= perf_forced_q + 32'd1;
      end
    end
  end

  assign perf_cpu_stall_cycles = perf_stall_q;
  assign perf_dma_forced       = perf_forced_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a transaction-level model (memory array, pending-read record).
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned LAT  = 1;
  localparam int unsigned SMAX = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perf_stall;
  logic [31:0] perf_forced;
`endif

  dmem_arbiter #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .READ_LAT  (LAT),
    .STARVE_MAX(SMAX)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .bus                  (bus)
`ifdef DMEM_ARB_PERF_EN
    ,
    .perf_cpu_stall_cycles(perf_stall),
    .perf_dma_forced      (perf_forced)
`endif
  );

  // Data memory with LAT cycles of read latency.
  logic [DW-1:0] mem [1024];
  logic [DW-1:0] rd_pipe [LAT];
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr[11:2]] <= bus.mem_din;
    rd_pipe[0] <= mem[bus.mem_addr[11:2]];
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.mem_dout = rd_pipe[LAT-1];

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0] ref_mem [1024];
  bit            pend;
  int            ret_cyc;
  bit            ret_dma;
  logic [DW-1:0] ret_data;
  logic [DW-1:0] exp_cpu_rdata, exp_dma_rdata;
  int            starve;
  int            cyc = 0;
  longint        exp_perf_stall, exp_perf_forced;
  bit            m_rv_cpu, m_rv_dma, m_dw, m_cw, m_we, m_stall;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_cpu_stall", bus.cpu_stall, 0);
      chk("rst_dma_gnt", bus.dma_gnt, 0);
      chk("rst_mem_we", bus.mem_we, 0);
      pend = 0;
      exp_cpu_rdata = '0;
      exp_dma_rdata = '0;
      starve = 0;
      exp_perf_stall = 0;
      exp_perf_forced = 0;
    end else begin
      m_rv_cpu = pend && (cyc == ret_cyc) && !ret_dma;
      m_rv_dma = pend && (cyc == ret_cyc) && ret_dma;
      if (pend && (cyc == ret_cyc)) begin
        if (ret_dma) exp_dma_rdata = ret_data;
        else exp_cpu_rdata = ret_data;
        pend = 0;
      end
      m_dw    = !pend && bus.dma_req && (!bus.cpu_req || (starve == SMAX));
      m_cw    = !pend && bus.cpu_req && !m_dw;
      m_we    = m_dw ? bus.dma_we : bus.cpu_we;
      m_addr  = m_dw ? bus.dma_addr : bus.cpu_addr;
      m_wdata = m_dw ? bus.dma_wdata : bus.cpu_wdata;
      m_stall = bus.cpu_req && !(m_cw && bus.cpu_we) && !m_rv_cpu;

      chk("cpu_stall", bus.cpu_stall, m_stall);
      chk("dma_gnt", bus.dma_gnt, m_dw);
      chk("mem_we", bus.mem_we, (m_dw || m_cw) && m_we);
      chk("cpu_rvalid", bus.cpu_rvalid, m_rv_cpu);
      chk("dma_rvalid", bus.dma_rvalid, m_rv_dma);
      chk("cpu_rdata", bus.cpu_rdata, exp_cpu_rdata);
      chk("dma_rdata", bus.dma_rdata, exp_dma_rdata);
      if (m_dw || m_cw) begin
        chk("mem_addr", bus.mem_addr, m_addr);
        if (m_we) chk("mem_din", bus.mem_din, m_wdata);
      end
`ifdef DMEM_ARB_PERF_EN
      chk("perf_stall", perf_stall, exp_perf_stall);
      chk("perf_forced", perf_forced, exp_perf_forced);
      if (m_stall) exp_perf_stall++;
      if (m_dw && bus.cpu_req) exp_perf_forced++;
`endif
      if (m_dw || m_cw) begin
        if (m_we) begin
          ref_mem[m_addr[11:2]] = m_wdata;
        end else begin
          pend     = 1;
          ret_cyc  = cyc + LAT + 1;
          ret_dma  = m_dw;
          ret_data = ref_mem[m_addr[11:2]];
        end
      end
      if (!bus.dma_req || m_dw) starve = 0;
      else if (starve < SMAX) starve++;
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  bit       prev_stall, prev_gnt;
  logic [9:0] r_word;

  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic to_sample();
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      to_drive();
      bus.cpu_req = 1'b0;
      bus.dma_req = 1'b0;
      rst = 1'b0;
      to_sample();
    end
  endtask

  task automatic cpu_drive(input bit req, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
    bus.cpu_req   = req;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
  endtask

  task automatic dma_drive(input bit req, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
    bus.dma_req   = req;
    bus.dma_we    = we;
    bus.dma_addr  = addr;
    bus.dma_wdata = wdata;
  endtask

  // Scenario 2: a load of 0x100 held through its return cycle.
  task automatic cpu_load_100(input string tag);
    to_drive(); cpu_drive(1, 0, 32'h100, 32'h0);
    to_sample(); chk({tag, "_stall0"}, bus.cpu_stall, 1);
    to_drive();
    to_sample(); chk({tag, "_stall1"}, bus.cpu_stall, 1);
    chk({tag, "_norv1"}, bus.cpu_rvalid, 0);
    to_drive();
    to_sample(); chk({tag, "_rv"}, bus.cpu_rvalid, 1);
    chk({tag, "_rdata"}, bus.cpu_rdata, 32'hDEADBEEF);
    chk({tag, "_stall2"}, bus.cpu_stall, 0);
    idle(3);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = 32'hA5A5_0000 ^ i;
      ref_mem[i] = 32'hA5A5_0000 ^ i;
    end
    rst = 1'b1;
    cpu_drive(0, 0, 0, 0);
    dma_drive(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    to_sample();
    chk("reset_cpu_rvalid", bus.cpu_rvalid, 0);
    chk("reset_dma_rvalid", bus.dma_rvalid, 0);
    chk("reset_cpu_rdata", bus.cpu_rdata, 0);
    chk("reset_dma_rdata", bus.dma_rdata, 0);

    // 1: CPU store, memory free -> same-cycle write, no stall
    to_drive(); cpu_drive(1, 1, 32'h100, 32'hDEADBEEF);
    to_sample();
    chk("t1_mem_we", bus.mem_we, 1);
    chk("t1_mem_addr", bus.mem_addr, 32'h100);
    chk("t1_mem_din", bus.mem_din, 32'hDEADBEEF);
    chk("t1_stall", bus.cpu_stall, 0);
    chk("t1_rvalid", bus.cpu_rvalid, 0);

    // 2: CPU load, stalled READ_LAT+1 cycles
    cpu_load_100("t2");

    // 3: simultaneous requests, CPU first, DMA in the rvalid cycle
    to_drive(); cpu_drive(1, 0, 32'h100, 0); dma_drive(1, 1, 32'h200, 32'h12345678);
    to_sample(); chk("t3_gnt0", bus.dma_gnt, 0); chk("t3_addr0", bus.mem_addr, 32'h100);
    to_drive();
    to_sample(); chk("t3_gnt1", bus.dma_gnt, 0);
    to_drive(); bus.cpu_req = 1'b0;
    to_sample();
    chk("t3_cpu_rv", bus.cpu_rvalid, 1);
    chk("t3_gnt2", bus.dma_gnt, 1);
    chk("t3_mem_we", bus.mem_we, 1);
    chk("t3_addr2", bus.mem_addr, 32'h200);
    idle(2);

    // 4: continuous CPU loads starve DMA until the counter reaches STARVE_MAX
    for (int k = 0; k < 10; k++) begin
      to_drive();
      cpu_drive(1, 0, 32'h200, 0);
      dma_drive(1, 1, 32'h300, 32'hCAFE0001);
      to_sample();
      chk($sformatf("t4_gnt_k%0d", k), bus.dma_gnt, (k == 8));
    end
    idle(3);

    // 5: reset during the wait of a DMA read
    to_drive(); dma_drive(1, 0, 32'h300, 0);
    to_sample(); chk("t5_gnt", bus.dma_gnt, 1);
    to_drive(); bus.dma_req = 1'b0; bus.cpu_req = 1'b1; rst = 1'b1;
    to_sample(); chk("t5_rst_stall", bus.cpu_stall, 0);
    to_drive(); rst = 1'b0; bus.cpu_req = 1'b0;
    to_sample();
    chk("t5_no_rv0", bus.dma_rvalid, 0);
    chk("t5_rdata", bus.dma_rdata, 0);
    chk("t5_cpu_rdata", bus.cpu_rdata, 0);
    to_drive();
    to_sample(); chk("t5_no_rv1", bus.dma_rvalid, 0);
    to_drive(); dma_drive(1, 0, 32'h300, 0);
    to_sample(); chk("t5_regnt", bus.dma_gnt, 1);
    to_drive(); bus.dma_req = 1'b0;
    to_sample();
    to_drive();
    to_sample();
    chk("t5_rv", bus.dma_rvalid, 1);
    chk("t5_rv_data", bus.dma_rdata, 32'hCAFE0001);
    idle(2);

`ifdef DMEM_ARB_PERF_EN
    // 6: three loads from a fresh reset -> six stall cycles, no forced grants
    to_drive(); rst = 1'b1;
    to_sample();
    idle(1);
    cpu_load_100("t6a");
    cpu_load_100("t6b");
    cpu_load_100("t6c");
    chk("t6_perf_stall", perf_stall, 6);
    chk("t6_perf_forced", perf_forced, 0);
`endif

    // Randomized traffic: CPU holds while stalled, DMA holds until granted.
    prev_stall = 1'b0;
    prev_gnt   = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      to_drive();
      rst = ($urandom_range(0, 299) == 0);
      if (!(bus.cpu_req && prev_stall)) begin
        r_word = 10'($urandom_range(0, 1023));
        cpu_drive($urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)), {20'd0, r_word, 2'b00}, $urandom);
      end
      if (!(bus.dma_req && !prev_gnt)) begin
        r_word = 10'($urandom_range(0, 1023));
        dma_drive($urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)), {20'd0, r_word, 2'b00}, $urandom);
      end
      to_sample();
      prev_stall = bus.cpu_stall;
      prev_gnt   = bus.dma_gnt;
    end
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-port data memory between the pipeline's memory-access stage (CPU port) and a secondary DMA/loader port (UART program/data loader).
- Sits between the memory-access stage's we/data_addr/din/dout signals and the data memory.
- Sequences read latency and returns load data to the winning requester.
- Raises a pipeline stall while the CPU access is pending.
- CPU has fixed priority; a starvation counter guarantees DMA progress.

Parameters:
- ADDR_W, 32, address width (byte address, passed through unmodified).
- DATA_W, 32, data width.
- READ_LAT, 1, data memory read latency in cycles; legal range 1..3.
- STARVE_MAX, 8, consecutive denied DMA-request cycles before DMA is forced a grant; legal range 1..255.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cpu_req  in  1  memory-stage access valid (load or store)
- cpu_we  in  1  1 = store
- cpu_addr  in  ADDR_W  access address
- cpu_wdata  in  DATA_W  store data
- cpu_stall  out  1  freeze pipeline stages up to and including memory access
- cpu_rvalid  out  1  load data valid (one-cycle pulse)
- cpu_rdata  out  DATA_W  load data
- dma_req  in  1  DMA access request; held until granted
- dma_we  in  1  1 = write
- dma_addr  in  ADDR_W  DMA address
- dma_wdata  in  DATA_W  DMA write data
- dma_gnt  out  1  request accepted this cycle
- dma_rvalid  out  1  DMA read data valid (one-cycle pulse)
- dma_rdata  out  DATA_W  DMA read data
- mem_we  out  1  to data memory
- mem_addr  out  ADDR_W  to data memory
- mem_din  out  DATA_W  to data memory
- mem_dout  in  DATA_W  from data memory

Behaviour:
- Clock and reset: one clock, clk; rst is synchronous active-high.
- Reset: state=IDLE, starve_cnt=0. mem_we, dma_gnt, cpu_rvalid and dma_rvalid are 0; cpu_rdata and dma_rdata are 0. While rst is high, cpu_stall=0.
- States:
  - IDLE: memory free; an access may issue this cycle.
  - READ_WAIT: one read outstanding; lat_cnt counts READ_LAT-1 down to 0. The owner of the outstanding read is registered.
- Arbitration (IDLE only):
  - DMA wins if dma_req and (!cpu_req or starve_cnt==STARVE_MAX).
  - Otherwise CPU wins if cpu_req.
- Issue cycle:
  - mem_addr/mem_din driven from the winner; mem_we = winner's we.
  - dma_gnt=1 when DMA wins.
  - Write: completes in the issue cycle; state stays IDLE.
  - Read: go to READ_WAIT.
- Return:
  - The cycle READ_LAT cycles after issue, mem_dout is registered into the owner's rdata.
  - The owner's rvalid pulses 1 cycle later, with state returning to IDLE in that same cycle.
  - Next issue is therefore possible in the rvalid cycle.
- Nothing issued: mem_we=0; mem_addr/mem_din follow the CPU port (don't-care).
- cpu_stall, combinational, is 1 when:
  - cpu_req && !(CPU write issued this cycle), and
  - not the cycle in which cpu_rvalid=1.
  - Consequently: CPU store with memory free → no stall. CPU load → stalled READ_LAT+1 cycles, released in the cpu_rvalid cycle.
- starve_cnt:
  - Increments (saturating at STARVE_MAX) each cycle dma_req=1 && dma_gnt=0.
  - Clears on dma_gnt or dma_req=0.
- Simultaneous requests: CPU wins unless the starvation condition holds. A forced DMA grant stalls the CPU for that cycle (and the read wait, if a DMA read).
- Reset mid-read: the outstanding read is discarded; no rvalid is produced after reset.
- READ_WAIT ignores new requests; only one outstanding read exists at any time.

Optional Feature:
DMEM_ARB_PERF_EN
- Defined: adds two 32-bit saturating outputs, both cleared by rst:
  - perf_cpu_stall_cycles: counts cycles with cpu_stall=1.
  - perf_dma_forced: counts starvation-forced DMA grants.
- Undefined: these ports and their counters do not exist.

Decomposition:
- Package dmem_arb_pkg:
  - state enum (ARB_IDLE, ARB_READ_WAIT).
  - owner enum (OWN_CPU, OWN_DMA).
  - STARVE_CNT_W localparam = 8.
- Single module; no sub-module warranted. The starvation counter stays inline.

Test Plan:
1. CPU store addr 0x100 data 0xDEADBEEF, no DMA → mem_we=1 same cycle, cpu_stall=0, no rvalid.
2. CPU load 0x100 with READ_LAT=1 → cpu_stall=1 for 2 cycles; cpu_rvalid=1 with cpu_rdata=0xDEADBEEF in the next cycle, where cpu_stall=0.
3. cpu_req and dma_req (write 0x200) together, CPU load → CPU issued first; dma_gnt=1 in the cpu_rvalid cycle, provided cpu_req is low then.
4. CPU continuous loads with dma_req held, STARVE_MAX=8 → dma_gnt asserted exactly once starve_cnt reaches 8; counter then 0.
5. rst pulsed 1 cycle during READ_WAIT of a DMA read → no dma_rvalid afterwards; outputs at reset values; next request serviced normally.
6. DMEM_ARB_PERF_EN defined, scenario 2 run three times → perf_cpu_stall_cycles=6, perf_dma_forced=0.
